qdec_lb_ring: RTL and testbench

QDEC_LB_RING -- requirements
Module: qdec_lb_ring

---
 rtl/qdec_cabac_package.sv | 23 ++
 rtl/qdec_lb_bank.sv | 43 ++++
 rtl/qdec_lb_ring.sv | 163 ++++++++++++++++
 tb/tb_qdec_lb_ring.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/qdec_cabac_package.sv
// Shared constants and types for the CABAC line-buffer ring.
// Default geometry for qdec_lb_ring and the per-cycle bank-handoff
// operation encoding used by the ring's occupancy logic.
package qdec_cabac_package;

  localparam int LB_NUM_BANKS = 2;
  localparam int LB_DATA_W    = 8;
  localparam int LB_ADDR_W    = 12;

  // Accepted handoff events in one cycle: {commit, release}
  typedef enum logic [1:0] {
    LB_OP_IDLE    = 2'b00,
    LB_OP_RELEASE = 2'b01,
    LB_OP_COMMIT  = 2'b10,
    LB_OP_BOTH    = 2'b11
  } lb_op_e;

  // Bank pointer width; a single bank still needs one bit of pointer
  function automatic int lb_ptr_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/qdec_lb_bank.sv
// One CTU syntax bank: 2^ADDR_W x DATA_W RAM with a single write port
// and a registered read port. The read register resets to zero so the
// ring's read data is clean after reset; the array itself is never cleared.
module qdec_lb_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // RAM write port (no reset so the array maps onto block memory)
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; holds its value when not enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end else begin
      r_rd_data <= r_rd_data;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/qdec_lb_ring.sv
// CABAC line-buffer ring: NUM_BANKS CTU syntax banks handed from a writer
// to a reader in ring order. The writer fills bank wr_ptr and commits it;
// the reader reads bank rd_ptr and releases it.
// Optional feature: define QDEC_LB_ERR_EN to get sticky overflow/underflow
// flags; otherwise both flags are constant zero and have no flops.
module qdec_lb_ring
  import qdec_cabac_package::*;
#(
  parameter int NUM_BANKS = LB_NUM_BANKS,
  parameter int DATA_W    = LB_DATA_W,
  parameter int ADDR_W    = LB_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_W-1:0]              i_wr_addr,
  input  logic [DATA_W-1:0]              i_wr_data,
  input  logic                           i_wr_en,
  input  logic                           i_wr_commit,
  output logic                           o_wr_rdy,
  input  logic [ADDR_W-1:0]              i_rd_addr,
  input  logic                           i_rd_en,
  output logic [DATA_W-1:0]              o_rd_data,
  output logic                           o_rd_vld,
  input  logic                           i_rd_release,
  output logic [$clog2(NUM_BANKS+1)-1:0] o_count,
  output logic                           o_err_ovf,
  output logic                           o_err_udf
);

  localparam int CNT_W = $clog2(NUM_BANKS + 1);
  localparam int PTR_W = lb_ptr_w(NUM_BANKS);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_rd_sel;
  logic [CNT_W-1:0]  r_count;
  logic              r_wr_rdy;
  logic              r_rd_vld;

  logic              w_commit;
  logic              w_release;
  lb_op_e            w_op;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_bank_q [NUM_BANKS];
  logic [DATA_W-1:0] w_rd_data;

  // Only handoffs the ring can honour change state
  assign w_commit  = i_wr_commit && r_wr_rdy;
  assign w_release = i_rd_release && r_rd_vld;

  // Next pointers (wrap at NUM_BANKS-1) and next occupancy
  always_comb begin
    w_op = lb_op_e'({w_commit, w_release});
    if (w_commit) begin
      if (r_wr_ptr == PTR_W'(NUM_BANKS - 1)) begin
        w_wr_ptr_nxt = '0;
      end else begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_release) begin
      if (r_rd_ptr == PTR_W'(NUM_BANKS - 1)) begin
        w_rd_ptr_nxt = '0;
      end else begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    case (w_op)
      LB_OP_IDLE:    w_count_nxt = r_count;
      LB_OP_COMMIT:  w_count_nxt = r_count + CNT_W'(1);
      LB_OP_RELEASE: w_count_nxt = r_count - CNT_W'(1);
      LB_OP_BOTH:    w_count_nxt = r_count;
      default:       w_count_nxt = r_count;
    endcase
  end

  // Ring state; ready/valid are registered from the next occupancy, and the
  // read bank is captured at the rd_en cycle so a same-cycle release is harmless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rd_sel <= '0;
      r_count  <= '0;
      r_wr_rdy <= 1'b1;
      r_rd_vld <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_wr_rdy <= (w_count_nxt < CNT_W'(NUM_BANKS));
      r_rd_vld <= (w_count_nxt != '0);
      if (i_rd_en && r_rd_vld) begin
        r_rd_sel <= r_rd_ptr;
      end else begin
        r_rd_sel <= r_rd_sel;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    qdec_lb_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (i_wr_en && r_wr_rdy && (r_wr_ptr == PTR_W'(g))),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_rd_en   (i_rd_en && r_rd_vld && (r_rd_ptr == PTR_W'(g))),
      .i_rd_addr (i_rd_addr),
      .o_rd_data (w_bank_q[g])
    );
  end

  // Read data mux driven by the bank select registered with the RAM read
  always_comb begin
    w_rd_data = w_bank_q[r_rd_sel];
  end

  assign o_rd_data = w_rd_data;
  assign o_wr_rdy  = r_wr_rdy;
  assign o_rd_vld  = r_rd_vld;
  assign o_count   = r_count;

`ifdef QDEC_LB_ERR_EN
  logic r_err_ovf;
  logic r_err_udf;

  // Sticky flags for rejected commits (ring full) and releases (ring empty)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if (i_wr_commit && !r_wr_rdy) begin
        r_err_ovf <= 1'b1;
      end else begin
        r_err_ovf <= r_err_ovf;
      end
      if (i_rd_release && !r_rd_vld) begin
        r_err_udf <= 1'b1;
      end else begin
        r_err_udf <= r_err_udf;
      end
    end
  end

  assign o_err_ovf = r_err_ovf;
  assign o_err_udf = r_err_udf;
`else
  assign o_err_ovf = 1'b0;
  assign o_err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_qdec_lb_ring.sv
// Directed testbench for qdec_lb_ring with a four-bank ring.
module tb_qdec_lb_ring;

  localparam int NB = 4;
  localparam int DW = 8;
  localparam int AW = 12;
`ifdef QDEC_LB_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_commit;
  logic          wr_rdy;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic          rd_release;
  logic [2:0]    count;
  logic          err_ovf;
  logic          err_udf;

  int n_tests = 0;
  int n_fail  = 0;

  qdec_lb_ring #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_wr_en      (wr_en),
    .i_wr_commit  (wr_commit),
    .o_wr_rdy     (wr_rdy),
    .i_rd_addr    (rd_addr),
    .i_rd_en      (rd_en),
    .o_rd_data    (rd_data),
    .o_rd_vld     (rd_vld),
    .i_rd_release (rd_release),
    .o_count      (count),
    .o_err_ovf    (err_ovf),
    .o_err_udf    (err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    idle_inputs();
    step(); step();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_wr_rdy: got %b want 1", wr_rdy); end
    n_tests++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_vld: got %b want 0", rd_vld); end
    n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_tests++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b want 00", err_ovf, err_udf); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 12'd3; wr_data = 8'hA5; wr_commit = 1'b1;
    step();
    idle_inputs();
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL wr_count: got %0d want 1", count); end
    n_tests++; if (rd_vld !== 1'b1) begin n_fail++; $display("FAIL wr_rd_vld: got %b want 1", rd_vld); end
    n_tests++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_wr_rdy: got %b want 1", wr_rdy); end
    rd_en = 1'b1; rd_addr = 12'd3;
    step();
    rd_en = 1'b0;
    n_tests++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL rd_first: got %h want a5", rd_data); end
    rd_addr = 12'd0;
    step();
    n_tests++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL rd_hold: got %h want a5", rd_data); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_addr = 12'd5; wr_data = 8'(8'h11 * i); wr_commit = 1'b1;
      step();
    end
    idle_inputs();
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
    n_tests++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL full_wr_rdy: got %b want 0", wr_rdy); end
    wr_en = 1'b1; wr_addr = 12'd3; wr_data = 8'hFF; wr_commit = 1'b1;
    step();
    idle_inputs();
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", count); end
    n_tests++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL ovf_wr_rdy: got %b want 0", wr_rdy); end
    n_tests++; if (err_ovf !== ERR_ON) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", err_ovf, ERR_ON); end
  endtask

  task automatic test_release_read();
    // read bank 0 while releasing it; the dropped 0xFF write must not appear
    rd_en = 1'b1; rd_addr = 12'd3; rd_release = 1'b1;
    step();
    idle_inputs();
    n_tests++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL rel_rd_same: got %h want a5", rd_data); end
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL rel_count: got %0d want 3", count); end
    n_tests++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL rel_wr_rdy: got %b want 1", wr_rdy); end
    rd_en = 1'b1; rd_addr = 12'd5;
    step();
    idle_inputs();
    n_tests++; if (rd_data !== 8'h11) begin n_fail++; $display("FAIL rd_bank1: got %h want 11", rd_data); end
    rd_release = 1'b1;
    step(); step();
    idle_inputs();
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL rel2_count: got %0d want 1", count); end
    rd_en = 1'b1; rd_addr = 12'd5;
    step();
    idle_inputs();
    n_tests++; if (rd_data !== 8'h33) begin n_fail++; $display("FAIL rd_bank3: got %h want 33", rd_data); end
  endtask

  task automatic test_simultaneous();
    // rd_ptr=3 wraps to 0, wr_ptr 0 -> 1, write lands in bank 0
    wr_en = 1'b1; wr_addr = 12'd7; wr_data = 8'h77; wr_commit = 1'b1; rd_release = 1'b1;
    step();
    idle_inputs();
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL sim_count: got %0d want 1", count); end
    n_tests++; if (rd_vld !== 1'b1 || wr_rdy !== 1'b1) begin n_fail++; $display("FAIL sim_flags: got vld=%b rdy=%b want 1 1", rd_vld, wr_rdy); end
    rd_en = 1'b1; rd_addr = 12'd7;
    step();
    idle_inputs();
    n_tests++; if (rd_data !== 8'h77) begin n_fail++; $display("FAIL sim_wrap_rd: got %h want 77", rd_data); end
  endtask

  task automatic test_underflow();
    rd_release = 1'b1;
    step();
    idle_inputs();
    n_tests++; if (count !== 3'd0 || rd_vld !== 1'b0) begin n_fail++; $display("FAIL empty: got cnt=%0d vld=%b want 0 0", count, rd_vld); end
    rd_release = 1'b1;
    step();
    idle_inputs();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL udf_count: got %0d want 0", count); end
    n_tests++; if (err_udf !== ERR_ON) begin n_fail++; $display("FAIL udf_flag: got %b want %b", err_udf, ERR_ON); end
    n_tests++; if (err_ovf !== ERR_ON) begin n_fail++; $display("FAIL ovf_sticky: got %b want %b", err_ovf, ERR_ON); end
    rd_en = 1'b1; rd_addr = 12'd3;
    step();
    idle_inputs();
    n_tests++; if (rd_data !== 8'h77) begin n_fail++; $display("FAIL rd_empty_hold: got %h want 77", rd_data); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1; wr_addr = 12'd9; wr_data = 8'(8'h90 + i); wr_commit = 1'b1;
      step();
    end
    idle_inputs();
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL pre_rst_count: got %0d want 2", count); end
    wr_en = 1'b1; wr_addr = 12'd9; wr_data = 8'hEE;
    #2;
    rst_n = 1'b0; wr_en = 1'b0;
    #1;
    n_tests++; if (count !== 3'd0 || rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_async: got cnt=%0d data=%h want 0 00", count, rd_data); end
    step();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    n_tests++; if (rd_vld !== 1'b0 || wr_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flags: got vld=%b rdy=%b want 0 1", rd_vld, wr_rdy); end
    n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h want 00", rd_data); end
    n_tests++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b%b want 00", err_ovf, err_udf); end
    rst_n = 1'b1;
    step();
    wr_commit = 1'b1;
    step();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 12'd7;
    step();
    idle_inputs();
    n_tests++; if (rd_data !== 8'h77) begin n_fail++; $display("FAIL ram_kept: got %h want 77", rd_data); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_overflow();
    test_release_read();
    test_simultaneous();
    test_underflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
